// File: rtl/ddr_test_pkg.sv
//------------------------------------------------------------------------------
// Module  : ddr_test_pkg
// Brief   : Shared types, widths and PRBS31 word-step helper for the DDR test.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ddr_test_pkg;

  localparam int BEAT_W  = 128;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Word MSB holds the oldest sequence bit; each step yields the next 128 bits
  // of s[n] = s[n-31] ^ s[n-28].
  function automatic logic [BEAT_W-1:0] prbs31_step(input logic [BEAT_W-1:0] cur);
    logic [2*BEAT_W-1:0] ext;
    logic [BEAT_W-1:0]   nxt;
    ext = '0;
    nxt = '0;
    for (int j = 0; j < BEAT_W; j++) begin
      ext[j] = cur[BEAT_W-1-j];
    end
    for (int j = BEAT_W; j < 2*BEAT_W; j++) begin
      ext[j] = ext[j-31] ^ ext[j-28];
    end
    for (int j = 0; j < BEAT_W; j++) begin
      nxt[BEAT_W-1-j] = ext[BEAT_W+j];
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs31_128bit.sv
//------------------------------------------------------------------------------
// Module  : prbs31_128bit
// Brief   : 128-bit-per-cycle PRBS31 / counter data generator with sync reseed.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prbs31_128bit
  import ddr_test_pkg::*;
#(
  parameter logic [BEAT_W-1:0] PRBS_INIT   = 128'h1,
  parameter bit                PRBS_GEN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clk_en,
  input  logic              seed_load,
  input  logic              cnt_mode,
  input  logic              insert_er,
  output logic [BEAT_W-1:0] dout
);

  generate
    if (PRBS_GEN_EN) begin : g_gen_on
      logic [BEAT_W-1:0] r_state;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_state <= PRBS_INIT;
        end else if (seed_load) begin
          r_state <= PRBS_INIT;
        end else if (clk_en) begin
          r_state <= cnt_mode ? (r_state + {{(BEAT_W-1){1'b0}}, 1'b1})
                              : prbs31_step(r_state);
        end
      end

      assign dout = r_state ^ {{(BEAT_W-1){1'b0}}, insert_er};
    end else begin : g_gen_off
      assign dout = PRBS_INIT;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ddr_prbs_test_ctrl.sv
//------------------------------------------------------------------------------
// Module  : ddr_prbs_test_ctrl
// Brief   : Writes N bursts of PRBS31/counter data to the DDR user port, reads
//           them back and checks every beat against a regenerated reference.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr_prbs_test_ctrl
  import ddr_test_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter int                BURST_BEATS = 4,
  parameter int                ADDR_STEP   = 64,
  parameter logic [BEAT_W-1:0] PRBS_SEED   = 128'h1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              cnt_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_bursts,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [3:0]        first_err_beat,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              wdata_valid,
  input  logic              wdata_ready,
  output logic [BEAT_W-1:0] wdata,
  input  logic              rdata_valid,
  input  logic [BEAT_W-1:0] rdata
);

  localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(ADDR_STEP);
  localparam logic [3:0]        c_last_beat = 4'(BURST_BEATS - 1);

  state_e            r_state;
  state_e            w_next;

  logic              r_cnt_mode;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_num;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_burst_idx;
  logic [3:0]        r_beat;
  logic              r_abort;
  logic              r_inj_arm;
  logic [31:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_first_addr;
  logic [3:0]        r_first_beat;
  logic              r_pass;
  logic              r_busy;
  logic              r_done;

  logic              w_cmd_valid;
  logic              w_cmd_write;
  logic              w_wdata_valid;
  logic              w_in_done;

  logic              w_start_acc;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_last_beat;
  logic              w_last_burst;
  logic              w_abort_pend;
  logic              w_mismatch;
  logic [BEAT_W-1:0] w_gen_dout;
  logic [BEAT_W-1:0] w_chk_dout;

  assign w_start_acc  = (r_state == ST_IDLE) && start;
  assign w_wr_fire    = w_wdata_valid && wdata_ready;
  assign w_rd_fire    = (r_state == ST_RD_DATA) && rdata_valid;
  assign w_last_beat  = (r_beat == c_last_beat);
  assign w_last_burst = (r_burst_idx == (r_num - 16'd1));
  // An abort seen in the same cycle as a burst boundary still stops the test.
  assign w_abort_pend = r_abort || abort;
  assign w_mismatch   = (rdata != w_chk_dout);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (num_bursts == 16'd0) ? ST_DONE : ST_WR_CMD;
        end
      end
      ST_WR_CMD: begin
        if (cmd_ready) begin
          w_next = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (wdata_ready && w_last_beat) begin
          if (w_abort_pend) begin
            w_next = ST_DONE;
          end else if (w_last_burst) begin
            w_next = ST_RD_CMD;
          end else begin
            w_next = ST_WR_CMD;
          end
        end
      end
      ST_RD_CMD: begin
        if (cmd_ready) begin
          w_next = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (rdata_valid && w_last_beat) begin
          w_next = (w_abort_pend || w_last_burst) ? ST_DONE : ST_RD_CMD;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_cmd_valid   = 1'b0;
    w_cmd_write   = 1'b0;
    w_wdata_valid = 1'b0;
    w_in_done     = 1'b0;
    case (r_state)
      ST_WR_CMD: begin
        w_cmd_valid = 1'b1;
        w_cmd_write = 1'b1;
      end
      ST_WR_DATA: w_wdata_valid = 1'b1;
      ST_RD_CMD:  w_cmd_valid   = 1'b1;
      ST_DONE:    w_in_done     = 1'b1;
      default: begin
        w_cmd_valid = 1'b0;
      end
    endcase
  end

  // Test context, shared address/beat counters and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_mode   <= 1'b0;
      r_base       <= '0;
      r_num        <= '0;
      r_addr       <= '0;
      r_burst_idx  <= '0;
      r_beat       <= '0;
      r_abort      <= 1'b0;
      r_inj_arm    <= 1'b0;
      r_err_cnt    <= '0;
      r_first_addr <= '0;
      r_first_beat <= '0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_in_done;

      if (w_start_acc) begin
        r_cnt_mode   <= cnt_mode;
        r_base       <= base_addr;
        r_num        <= num_bursts;
        r_addr       <= base_addr;
        r_burst_idx  <= '0;
        r_beat       <= '0;
        r_abort      <= 1'b0;
        r_err_cnt    <= '0;
        r_first_addr <= '0;
        r_first_beat <= '0;
        r_pass       <= 1'b0;
        r_busy       <= 1'b1;
      end else if (abort && r_busy) begin
        r_abort <= 1'b1;
      end

      if (w_in_done) begin
        r_pass <= (r_err_cnt == 32'd0) && !r_abort;
        r_busy <= 1'b0;
      end

      // The flag is consumed by an accepted beat; a same-cycle pulse re-arms it.
      if (w_wr_fire) begin
        r_inj_arm <= inject_err;
      end else if (inject_err) begin
        r_inj_arm <= 1'b1;
      end

      if (w_wr_fire || w_rd_fire) begin
        if (w_last_beat) begin
          r_beat <= '0;
          if (w_wr_fire && w_last_burst) begin
            r_addr      <= r_base;
            r_burst_idx <= '0;
          end else begin
            r_addr      <= r_addr + c_addr_step;
            r_burst_idx <= r_burst_idx + 16'd1;
          end
        end else begin
          r_beat <= r_beat + 4'd1;
        end
      end

      if (w_rd_fire && w_mismatch) begin
        if (r_err_cnt == 32'd0) begin
          r_first_addr <= r_addr;
          r_first_beat <= r_beat;
        end
        if (r_err_cnt != 32'hFFFF_FFFF) begin
          r_err_cnt <= r_err_cnt + 32'd1;
        end
      end
    end
  end

  prbs31_128bit #(
    .PRBS_INIT   (PRBS_SEED),
    .PRBS_GEN_EN (1'b1)
  ) u_wr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .clk_en    (w_wr_fire),
    .seed_load (w_start_acc),
    .cnt_mode  (r_cnt_mode),
    .insert_er (1'b0),
    .dout      (w_gen_dout)
  );

  prbs31_128bit #(
    .PRBS_INIT   (PRBS_SEED),
    .PRBS_GEN_EN (1'b1)
  ) u_rd_chk (
    .clk       (clk),
    .rstn      (rstn),
    .clk_en    (w_rd_fire),
    .seed_load (w_start_acc),
    .cnt_mode  (r_cnt_mode),
    .insert_er (1'b0),
    .dout      (w_chk_dout)
  );

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_addr;
  assign first_err_beat = r_first_beat;
  assign cmd_valid      = w_cmd_valid;
  assign cmd_write      = w_cmd_write;
  assign cmd_addr       = w_cmd_valid ? r_addr : '0;
  assign wdata_valid    = w_wdata_valid;
  assign wdata          = w_wdata_valid ? (w_gen_dout ^ {{(BEAT_W-1){1'b0}}, r_inj_arm}) : '0;

endmodule

`default_nettype wire

// File: tb/tb_ddr_prbs_test_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_ddr_prbs_test_ctrl
// Brief   : Directed self-checking bench with a small DDR user-port memory model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ddr_prbs_test_ctrl;

  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cnt_mode = 1'b0;
  logic          inject_err = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   num_bursts = '0;
  logic          busy, done, pass;
  logic [31:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [3:0]    first_err_beat;
  logic          cmd_valid, cmd_write;
  logic          cmd_ready = 1'b0;
  logic [AW-1:0] cmd_addr;
  logic          wdata_valid;
  logic          wdata_ready = 1'b0;
  logic [127:0]  wdata;
  logic          rdata_valid = 1'b0;
  logic [127:0]  rdata = '0;

  always #5 clk = ~clk;

  ddr_prbs_test_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .cnt_mode(cnt_mode),
    .base_addr(base_addr), .num_bursts(num_bursts), .inject_err(inject_err),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_beat(first_err_beat),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference PRBS31 words from seed 1, built bit-serially (MSB = oldest bit)
  logic [127:0] exp_prbs [0:15];
  initial begin
    bit sq [0:2047];
    logic [127:0] seed;
    seed = 128'h1;
    for (int j = 0; j < 128; j++) sq[j] = seed[127-j];
    for (int n = 128; n < 2048; n++) sq[n] = sq[n-31] ^ sq[n-28];
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 128; j++) exp_prbs[k][127-j] = sq[128*k+j];
  end

  // Memory model: handshakes decided and logged at the falling edge
  logic [127:0] wlog [$];
  logic [28:0]  clog [$];
  logic [127:0] rq [$];
  logic [127:0] mem [logic [31:0]];
  int           rd_n = 0;
  int           done_n = 0;
  bit           stall_en = 0;
  int           cw = -1;
  int           ww = -1;
  bit           c_stalled = 0;
  bit           w_stalled = 0;
  logic [AW-1:0] c_hold;
  logic [127:0]  w_hold;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_b = '0;

  always @(negedge clk) begin
    if (rq.size() > 0) begin
      rdata_valid = 1'b1;
      rdata = rq.pop_front();
      rd_n++;
    end else begin
      rdata_valid = 1'b0;
      rdata = '0;
    end
    if (done) done_n++;
    if (c_stalled) begin
      check_eq("cmd_hold_valid", cmd_valid, 1);
      check_eq("cmd_hold_addr", cmd_addr, c_hold);
    end
    if (w_stalled) begin
      check_eq("wdata_hold_valid", wdata_valid, 1);
      check_eq("wdata_hold_data", wdata, w_hold);
    end
    if (cmd_valid) begin
      if (cw < 0) cw = stall_en ? int'($urandom_range(0, 5)) : 0;
      cmd_ready = (cw == 0);
      if (cw > 0) cw--;
    end else cmd_ready = 1'b0;
    if (wdata_valid) begin
      if (ww < 0) ww = stall_en ? int'($urandom_range(0, 5)) : 0;
      wdata_ready = (ww == 0);
      if (ww > 0) ww--;
    end else wdata_ready = 1'b0;
    c_stalled = cmd_valid && !cmd_ready;
    c_hold    = cmd_addr;
    w_stalled = wdata_valid && !wdata_ready;
    w_hold    = wdata;
    if (cmd_valid && cmd_ready) begin
      cw = -1;
      clog.push_back({cmd_write, cmd_addr});
      if (cmd_write) begin
        wr_addr = cmd_addr;
        wr_b = '0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          logic [31:0] key;
          key = {cmd_addr, 4'(b)};
          rq.push_back(mem.exists(key) ? mem[key] : '0);
        end
      end
    end
    if (wdata_valid && wdata_ready) begin
      ww = -1;
      mem[{wr_addr, wr_b}] = wdata;
      wlog.push_back(wdata);
      wr_b = wr_b + 4'd1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input bit m, input logic [AW-1:0] b, input logic [15:0] n);
    wlog.delete();
    clog.delete();
    rd_n = 0;
    done_n = 0;
    cnt_mode = m;
    base_addr = b;
    num_bursts = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    check_eq(tag, got, 1);
  endtask

  task automatic wait_wlog(input string tag, input int n);
    bit got;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (wlog.size() >= n) begin
        got = 1;
        break;
      end
    end
    check_eq(tag, got, 1);
  endtask

  initial begin
    int nrd;
    bit got;

    // Reset state
    tick(); tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_wdata_valid", wdata_valid, 0);
    rstn = 1'b1;
    tick();

    // 1: PRBS pass, two bursts
    kick(0, 28'h100, 2);
    wait_done("s1_done", 200);
    check_eq("s1_pass", pass, 1);
    check_eq("s1_err_cnt", err_cnt, 0);
    check_eq("s1_busy", busy, 0);
    check_eq("s1_nwr", wlog.size(), 8);
    check_eq("s1_nrd", rd_n, 8);
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) check_eq($sformatf("s1_wbeat%0d", i), wlog[i], exp_prbs[i]);
      check_eq("s1_beat0_seed", wlog[0], 128'h1);
      check_eq("s1_beat1_top", wlog[1][127:96], 32'h0000_0012);
    end
    check_eq("s1_ncmd", clog.size(), 4);
    if (clog.size() == 4) begin
      check_eq("s1_cmd1", clog[1], {1'b1, 28'h140});
      check_eq("s1_cmd2", clog[2], {1'b0, 28'h100});
      check_eq("s1_cmd3", clog[3], {1'b0, 28'h140});
    end

    // 2: error injected into beat 5
    kick(0, 28'h2000, 2);
    wait_wlog("s2_reach5", 5);
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    wait_done("s2_done", 200);
    check_eq("s2_err_cnt", err_cnt, 1);
    check_eq("s2_first_addr", first_err_addr, 28'h2040);
    check_eq("s2_first_beat", first_err_beat, 1);
    check_eq("s2_pass", pass, 0);
    if (wlog.size() == 8) check_eq("s2_wbeat5", wlog[5], exp_prbs[5] ^ 128'h1);

    // 3: random backpressure
    stall_en = 1;
    kick(0, 28'h100, 2);
    wait_done("s3_done", 1000);
    stall_en = 0;
    check_eq("s3_pass", pass, 1);
    check_eq("s3_err_cnt", err_cnt, 0);
    check_eq("s3_nwr", wlog.size(), 8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++) check_eq($sformatf("s3_wbeat%0d", i), wlog[i], exp_prbs[i]);

    // 4: counter mode
    kick(1, 28'h300, 1);
    wait_done("s4_done", 200);
    check_eq("s4_pass", pass, 1);
    check_eq("s4_nwr", wlog.size(), 4);
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) check_eq($sformatf("s4_wbeat%0d", i), wlog[i], 128'(i + 1));

    // 5a: zero bursts
    kick(0, 28'h0, 0);
    check_eq("s5a_busy", busy, 1);
    check_eq("s5a_done_early", done, 0);
    tick();
    check_eq("s5a_done", done, 1);
    check_eq("s5a_pass", pass, 1);
    check_eq("s5a_busy_end", busy, 0);

    // 5b/5c: address wrap and a start while busy
    kick(0, 28'hFFFFFC0, 2);
    tick(); tick();
    base_addr = 28'h0;
    num_bursts = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("s5b_done", 200);
    check_eq("s5b_pass", pass, 1);
    check_eq("s5c_nwr", wlog.size(), 8);
    check_eq("s5b_ncmd", clog.size(), 4);
    if (clog.size() == 4) begin
      check_eq("s5b_cmd0", clog[0], {1'b1, 28'hFFFFFC0});
      check_eq("s5b_cmd1", clog[1], {1'b1, 28'h0});
      check_eq("s5b_cmd3", clog[3], {1'b0, 28'h0});
    end
    tick(); tick();
    check_eq("s5c_done_cnt", done_n, 1);

    // 6b: async reset in the middle of the read phase
    kick(0, 28'h1000, 2);
    inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      nrd = rd_n;
      if (nrd >= 2) begin
        got = 1;
        break;
      end
    end
    check_eq("s6b_reach_rd", got, 1);
    check_eq("s6b_err_before", err_cnt, 1);
    rstn = 1'b0;
    #1;
    check_eq("s6b_busy", busy, 0);
    check_eq("s6b_err_cnt", err_cnt, 0);
    check_eq("s6b_first_addr", first_err_addr, 0);
    check_eq("s6b_cmd_valid", cmd_valid, 0);
    check_eq("s6b_wdata_valid", wdata_valid, 0);
    check_eq("s6b_done", done, 0);
    tick(); tick();
    rq.delete();
    c_stalled = 0;
    w_stalled = 0;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("s6b_no_done", done_n, 0);
    check_eq("s6b_idle_busy", busy, 0);

    // 6a: abort during the first write burst
    kick(0, 28'h4000, 4);
    wait_wlog("s6a_reach1", 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("s6a_done", 200);
    check_eq("s6a_pass", pass, 0);
    check_eq("s6a_nwr", wlog.size(), 4);
    check_eq("s6a_ncmd", clog.size(), 1);
    check_eq("s6a_nrd", rd_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
